// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the buffered UART transmitter.
//   parity_e            : parity selection encoding (matches PARITY_TYPE values)
//   tx_state_e          : transmit FSM states
//   CLKS_PER_BIT_115200 : divisor for 115200 baud from a 50 MHz clock
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int CLKS_PER_BIT_115200 = 434;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO holding words waiting to be serialised.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (flushes pointers/count)
//   push/wdata : write request and data; ignored when full
//   pop/rdata  : read request; rdata always shows the head word
//   full/empty : occupancy flags
//   count      : number of words stored (0..DEPTH)
// Simultaneous push and pop are both honoured and leave count unchanged.
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : uart_sync_fifo

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
// UART transmitter with a small TX FIFO; frames are sent back to back.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   data_tx      : word to queue (BITS_N bits)
//   valid/ready  : producer handshake; a word is taken on a rising edge where
//                  valid && ready. ready is low while full and during reset.
//                  data_tx need only be stable at that edge.
//   uart_out     : serial line, idles high (registered)
//   busy         : frame in progress or FIFO non-empty
//   fifo_count   : words currently queued
//   baud_trigger : one-cycle pulse on the last clock of every bit period
// Frame: start(0), BITS_N data bits LSB first, optional parity, STOP_BITS x 1.
// -----------------------------------------------------------------------------
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BITS_N-1:0] data_tx,
    input  logic              valid,
    output logic              ready,
    output logic              uart_out,
    output logic              busy,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              baud_trigger
);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_buffered: CLKS_PER_BIT must be >= 2");
    end
    if (BITS_N < 5 || BITS_N > 9) begin : g_bad_bits
        $error("uart_tx_buffered: BITS_N must be in 5..9");
    end
    if (PARITY_TYPE < 0 || PARITY_TYPE > 2) begin : g_bad_parity
        $error("uart_tx_buffered: PARITY_TYPE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
    end

    localparam int CYC_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(BITS_N);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_N - 1);
    localparam logic STOP_LAST  = (STOP_BITS == 2);
    localparam bit   HAS_PARITY = (PARITY_TYPE != int'(PARITY_NONE));
    localparam bit   PAR_ODD    = (PARITY_TYPE == int'(PARITY_ODD));

    tx_state_e         state;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              stop_cnt;
    logic [BITS_N-1:0] shift_q;
    logic              parity_q;
    logic              line_q;

    logic [BITS_N-1:0] head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              bit_end;
    logic              frame_end;

    assign ready     = rst_n && !full;
    assign push      = valid && ready;
    assign bit_end   = (cyc_cnt == CYC_LAST);
    assign frame_end = (state == STOP) && bit_end && (stop_cnt == STOP_LAST);
    // The head is consumed from IDLE, or at the final stop clock so the next
    // start bit follows with no idle gap.
    assign pop       = !empty && ((state == IDLE) || frame_end);

    assign uart_out     = line_q;
    assign baud_trigger = (state != IDLE) && bit_end;
    assign busy         = (state != IDLE) || (fifo_count != '0);

    uart_sync_fifo #(
        .WIDTH (BITS_N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (data_tx),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // line_q is loaded with the level of the bit being entered, so the line
    // changes on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            line_q   <= 1'b1;
        end else begin
            if (state != IDLE) begin
                cyc_cnt <= bit_end ? '0 : cyc_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    line_q <= 1'b1;
                    if (pop) begin
                        shift_q  <= head;
                        parity_q <= PAR_ODD ? ~^head : ^head;
                        cyc_cnt  <= '0;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        line_q   <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        line_q  <= shift_q[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            stop_cnt <= 1'b0;
                            if (HAS_PARITY) begin
                                line_q <= parity_q;
                                state  <= PARITY;
                            end else begin
                                line_q <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift_q <= shift_q >> 1;
                            line_q  <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        stop_cnt <= 1'b0;
                        line_q   <= 1'b1;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == STOP_LAST) begin
                            if (pop) begin
                                shift_q  <= head;
                                parity_q <= PAR_ODD ? ~^head : ^head;
                                bit_cnt  <= '0;
                                stop_cnt <= 1'b0;
                                line_q   <= 1'b0;
                                state    <= START;
                            end else begin
                                line_q <= 1'b1;
                                state  <= IDLE;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    line_q <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule : uart_tx_buffered
